// File: rtl/pll_seq_pkg.sv
// rtl/pll_seq_pkg.sv - shared state encoding and default cycle constants for the PLL reset sequencer
package pll_seq_pkg;

  typedef enum logic [1:0] {
    ST_PLL_RST   = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STABLE    = 2'd2,
    ST_RUN       = 2'd3
  } seq_state_e;

  // Defaults are all derived from the 74.25 MHz reference clock.
  localparam int CLK_HZ            = 74_250_000;
  localparam int DEF_RST_CYCLES    = 16;
  localparam int DEF_LOCK_TIMEOUT  = CLK_HZ / 100;
  localparam int DEF_STABLE_CYCLES = CLK_HZ / 10_000;
  localparam int DEF_SYNC_STAGES   = 2;

  localparam logic [7:0] RETRY_MAX = 8'hFF;

  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return ($clog2(m + 1) < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sync_bit.sv
// rtl/sync_bit.sv - multi-flop synchroniser for a single asynchronous bit, resets to 0
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - sequences PLL reset, qualifies lock and releases the core reset
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES
) (
  input  logic       clk_74a,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       soft_rst_req,
  output logic       pll_rst,
  output logic       core_reset_n,
  output logic [1:0] seq_state,
  output logic [7:0] retry_cnt,
  output logic       lock_lost
);

  localparam int CNT_W = cnt_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  seq_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pll_rst;
  logic             r_core_reset_n;
  logic [7:0]       r_retry_cnt;
  logic             r_lock_lost;

  logic             w_lk_s;
  seq_state_e       w_state_nxt;
  logic             w_retry_inc;
  logic             w_lock_lost_nxt;
  logic             w_cnt_clr;

  sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .i_clk   (clk_74a),
    .i_rst_n (reset_n),
    .i_d     (pll_locked),
    .o_q     (w_lk_s)
  );

  // Soft reset request overrides every other transition, including lock loss.
  always_comb begin
    w_state_nxt     = r_state;
    w_retry_inc     = 1'b0;
    w_lock_lost_nxt = 1'b0;
    if (soft_rst_req) begin
      w_state_nxt = ST_PLL_RST;
    end else begin
      case (r_state)
        ST_PLL_RST: begin
          if (r_cnt == RST_LAST) w_state_nxt = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (w_lk_s) begin
            w_state_nxt = ST_STABLE;
          end else if (r_cnt == TIMEOUT_LAST) begin
            w_state_nxt = ST_PLL_RST;
            w_retry_inc = 1'b1;
          end
        end
        ST_STABLE: begin
          if (!w_lk_s) begin
            w_state_nxt = ST_WAIT_LOCK;
          end else if (r_cnt == STABLE_LAST) begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_RUN: begin
          if (!w_lk_s) begin
            w_state_nxt     = ST_PLL_RST;
            w_retry_inc     = 1'b1;
            w_lock_lost_nxt = 1'b1;
          end
        end
        default: w_state_nxt = ST_PLL_RST;
      endcase
    end
  end

  assign w_cnt_clr = soft_rst_req || (w_state_nxt != r_state);

  // Outputs are registered from the next state so the resets seen downstream are glitch-free.
  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= ST_PLL_RST;
      r_cnt          <= '0;
      r_pll_rst      <= 1'b1;
      r_core_reset_n <= 1'b0;
      r_retry_cnt    <= 8'd0;
      r_lock_lost    <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_pll_rst      <= (w_state_nxt == ST_PLL_RST);
      r_core_reset_n <= (w_state_nxt == ST_RUN);
      r_lock_lost    <= w_lock_lost_nxt;
      if (w_cnt_clr || (r_state == ST_RUN)) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_ONE;
      end
      if (w_retry_inc && (r_retry_cnt != RETRY_MAX)) begin
        r_retry_cnt <= r_retry_cnt + 8'd1;
      end
    end
  end

  assign pll_rst      = r_pll_rst;
  assign core_reset_n = r_core_reset_n;
  assign seq_state    = r_state;
  assign retry_cnt    = r_retry_cnt;
  assign lock_lost    = r_lock_lost;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - scoreboard bench for pll_reset_sequencer with short sim timing
module tb_pll_reset_sequencer;

  localparam int P_RST = 4;
  localparam int P_TO  = 100;
  localparam int P_STB = 16;

  localparam int SIG_PLL  = 0;
  localparam int SIG_CORE = 1;
  localparam int SIG_SEQ  = 2;
  localparam int SIG_RTY  = 3;
  localparam int SIG_LOST = 4;

  typedef struct {
    int    cyc;
    int    sig;
    int    val;
    string tag;
  } exp_t;

  logic       clk_74a = 1'b0;
  logic       reset_n = 1'b1;
  logic       pll_locked = 1'b1;
  logic       soft_rst_req = 1'b0;
  logic       pll_rst;
  logic       core_reset_n;
  logic [1:0] seq_state;
  logic [7:0] retry_cnt;
  logic       lock_lost;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sbq[$];

  always #5 clk_74a = ~clk_74a;
  always @(posedge clk_74a) cyc <= cyc + 1;

  pll_reset_sequencer #(
    .RST_CYCLES    (P_RST),
    .LOCK_TIMEOUT  (P_TO),
    .STABLE_CYCLES (P_STB),
    .SYNC_STAGES   (2)
  ) dut (
    .clk_74a      (clk_74a),
    .reset_n      (reset_n),
    .pll_locked   (pll_locked),
    .soft_rst_req (soft_rst_req),
    .pll_rst      (pll_rst),
    .core_reset_n (core_reset_n),
    .seq_state    (seq_state),
    .retry_cnt    (retry_cnt),
    .lock_lost    (lock_lost)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int sample(input int sig);
    case (sig)
      SIG_PLL:  return int'(pll_rst);
      SIG_CORE: return int'(core_reset_n);
      SIG_SEQ:  return int'(seq_state);
      SIG_RTY:  return int'(retry_cnt);
      default:  return int'(lock_lost);
    endcase
  endfunction

  task automatic push_exp(input int c, input int sig, input int val, input string tag);
    exp_t e;
    e.cyc = c;
    e.sig = sig;
    e.val = val;
    e.tag = $sformatf("%s@%0d", tag, c);
    sbq.push_back(e);
  endtask

  task automatic sb_compare();
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].cyc == cyc) begin
        check(sbq[i].tag, sample(sbq[i].sig), sbq[i].val);
        sbq.delete(i);
      end else if (sbq[i].cyc < cyc) begin
        check({"stale_", sbq[i].tag}, cyc, sbq[i].cyc);
        sbq.delete(i);
      end
    end
  endtask

  // Compare on the falling edge, then return just after the next rising edge to drive.
  task automatic tick();
    @(negedge clk_74a);
    sb_compare();
    @(posedge clk_74a);
    #1;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_pll_rst"}, int'(pll_rst), 1);
    check({tag, "_core"}, int'(core_reset_n), 0);
    check({tag, "_seq"}, int'(seq_state), 0);
    check({tag, "_retry"}, int'(retry_cnt), 0);
    check({tag, "_lost"}, int'(lock_lost), 0);
  endtask

  int base, t, u, s, v;

  initial begin
    #1 reset_n = 1'b0;
    #1 check_reset_vals("por");
    repeat (3) tick();

    // Power-up with lock already present
    reset_n = 1'b1;
    base = cyc;
    for (int k = 0; k < P_RST; k++) begin
      push_exp(base + k, SIG_PLL, 1, "s1_pll_rst");
      push_exp(base + k, SIG_SEQ, 0, "s1_seq");
    end
    push_exp(base + 4, SIG_PLL, 0, "s1_pll_rst");
    push_exp(base + 4, SIG_SEQ, 1, "s1_seq");
    push_exp(base + 5, SIG_SEQ, 2, "s1_seq");
    push_exp(base + 20, SIG_CORE, 0, "s1_core");
    push_exp(base + 20, SIG_SEQ, 2, "s1_seq");
    push_exp(base + 21, SIG_CORE, 1, "s1_core");
    push_exp(base + 21, SIG_SEQ, 3, "s1_seq");
    push_exp(base + 21, SIG_RTY, 0, "s1_retry");
    run_to(base + 30);

    // Lock loss in RUN, then re-lock
    t = cyc;
    pll_locked = 1'b0;
    push_exp(t + 2, SIG_CORE, 1, "s3_core");
    push_exp(t + 2, SIG_LOST, 0, "s3_lost");
    push_exp(t + 3, SIG_LOST, 1, "s3_lost");
    push_exp(t + 3, SIG_CORE, 0, "s3_core");
    push_exp(t + 3, SIG_SEQ, 0, "s3_seq");
    push_exp(t + 3, SIG_RTY, 1, "s3_retry");
    push_exp(t + 4, SIG_LOST, 0, "s3_lost");
    for (int k = 3; k < 3 + P_RST; k++) push_exp(t + k, SIG_PLL, 1, "s3_pll_rst");
    push_exp(t + 7, SIG_PLL, 0, "s3_pll_rst");
    push_exp(t + 7, SIG_SEQ, 1, "s3_seq");
    push_exp(t + 8, SIG_SEQ, 2, "s3_seq");
    push_exp(t + 23, SIG_SEQ, 2, "s3_seq");
    push_exp(t + 23, SIG_CORE, 0, "s3_core");
    push_exp(t + 24, SIG_SEQ, 3, "s3_seq");
    push_exp(t + 24, SIG_CORE, 1, "s3_core");
    push_exp(t + 24, SIG_RTY, 1, "s3_retry");
    run_to(t + 5);
    pll_locked = 1'b1;
    run_to(t + 30);

    // Soft reset coinciding with lock loss suppresses lock_lost and retry
    u = cyc;
    pll_locked = 1'b0;
    push_exp(u + 2, SIG_SEQ, 3, "pri_seq");
    push_exp(u + 3, SIG_SEQ, 0, "pri_seq");
    push_exp(u + 3, SIG_LOST, 0, "pri_lost");
    push_exp(u + 3, SIG_CORE, 0, "pri_core");
    push_exp(u + 3, SIG_RTY, 1, "pri_retry");
    push_exp(u + 4, SIG_LOST, 0, "pri_lost");
    push_exp(u + 7, SIG_SEQ, 1, "pri_seq");
    push_exp(u + 8, SIG_SEQ, 2, "pri_seq");
    push_exp(u + 24, SIG_SEQ, 3, "pri_seq");
    push_exp(u + 24, SIG_CORE, 1, "pri_core");
    run_to(u + 2);
    soft_rst_req = 1'b1;
    run_to(u + 3);
    soft_rst_req = 1'b0;
    pll_locked = 1'b1;
    run_to(u + 30);

    // Soft reset held 10 cycles in RUN, then a 1-cycle lock glitch in STABLE at cnt=10
    s = cyc;
    soft_rst_req = 1'b1;
    push_exp(s, SIG_SEQ, 3, "s5_seq");
    push_exp(s, SIG_CORE, 1, "s5_core");
    push_exp(s, SIG_PLL, 0, "s5_pll_rst");
    push_exp(s + 1, SIG_SEQ, 0, "s5_seq");
    push_exp(s + 1, SIG_CORE, 0, "s5_core");
    for (int k = 1; k <= 13; k++) begin
      push_exp(s + k, SIG_PLL, 1, "s5_pll_rst");
      push_exp(s + k, SIG_LOST, 0, "s5_lost");
    end
    push_exp(s + 14, SIG_PLL, 0, "s5_pll_rst");
    push_exp(s + 14, SIG_SEQ, 1, "s5_seq");
    push_exp(s + 15, SIG_SEQ, 2, "s5_seq");
    push_exp(s + 25, SIG_SEQ, 2, "s4_seq");
    push_exp(s + 26, SIG_SEQ, 1, "s4_seq");
    push_exp(s + 26, SIG_CORE, 0, "s4_core");
    push_exp(s + 27, SIG_SEQ, 2, "s4_seq");
    push_exp(s + 30, SIG_RTY, 1, "s4_retry");
    push_exp(s + 42, SIG_SEQ, 2, "s4_seq");
    push_exp(s + 42, SIG_CORE, 0, "s4_core");
    push_exp(s + 43, SIG_SEQ, 3, "s4_seq");
    push_exp(s + 43, SIG_CORE, 1, "s4_core");
    run_to(s + 10);
    soft_rst_req = 1'b0;
    run_to(s + 23);
    pll_locked = 1'b0;
    run_to(s + 24);
    pll_locked = 1'b1;
    run_to(s + 46);

    // Async reset mid-STABLE
    v = cyc;
    soft_rst_req = 1'b1;
    push_exp(v + 5, SIG_SEQ, 1, "s6_seq");
    push_exp(v + 6, SIG_SEQ, 2, "s6_seq");
    push_exp(v + 12, SIG_SEQ, 2, "s6_seq");
    push_exp(v + 12, SIG_RTY, 1, "s6_retry");
    run_to(v + 1);
    soft_rst_req = 1'b0;
    run_to(v + 12);
    @(negedge clk_74a);
    sb_compare();
    #2 reset_n = 1'b0;
    #1 check_reset_vals("s6_async");
    @(posedge clk_74a);
    #1 check_reset_vals("s6_hold");
    pll_locked = 1'b0;
    repeat (3) tick();

    // Restart with no lock: periodic timeouts and retry saturation
    reset_n = 1'b1;
    base = cyc;
    push_exp(base + 103, SIG_SEQ, 1, "s2_seq");
    push_exp(base + 103, SIG_RTY, 0, "s2_retry");
    push_exp(base + 103, SIG_PLL, 0, "s2_pll_rst");
    push_exp(base + 104, SIG_SEQ, 0, "s2_seq");
    push_exp(base + 104, SIG_PLL, 1, "s2_pll_rst");
    push_exp(base + 104, SIG_RTY, 1, "s2_retry");
    push_exp(base + 107, SIG_PLL, 1, "s2_pll_rst");
    push_exp(base + 108, SIG_PLL, 0, "s2_pll_rst");
    push_exp(base + 108, SIG_SEQ, 1, "s2_seq");
    push_exp(base + 208, SIG_RTY, 2, "s2_retry");
    push_exp(base + 208, SIG_PLL, 1, "s2_pll_rst");
    push_exp(base + 312, SIG_RTY, 3, "s2_retry");
    push_exp(base + 312, SIG_CORE, 0, "s2_core");
    push_exp(base + 104 * 255 - 1, SIG_RTY, 254, "s2_retry");
    push_exp(base + 104 * 255, SIG_RTY, 255, "s2_retry");
    push_exp(base + 104 * 300 + 2, SIG_RTY, 255, "s2_retry");
    push_exp(base + 104 * 300 + 2, SIG_SEQ, 0, "s2_seq");
    push_exp(base + 104 * 300 + 2, SIG_PLL, 1, "s2_pll_rst");
    run_to(base + 104 * 300 + 5);

    check("sb_drain", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
